alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//  Multi-cycle unsigned multiplier sequencer built around the shared combinational ALU.
//  Accepts WIDTH x WIDTH operands on a start strobe and computes the 2*WIDTH product by
//  shift-add. Every addition goes through the external ALU (control 3'b010, add).
//  Sits beside the ALU in the datapath; the datapath muxes ALU inputs to this block while o_busy=1.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH; must match the ALU WIDTH; WIDTH>=2
// PORTS
//  i_clk          in   1        clock, rising edge
//  i_rst_n        in   1        asynchronous, active-low reset
//  i_start        in   1        start request; accepted only when o_busy=0
//  i_a            in   WIDTH    multiplicand, sampled on accepted start
//  i_b            in   WIDTH    multiplier, sampled on accepted start
//  o_busy         out  1        high while in RUN
//  o_done         out  1        one-cycle pulse: product valid
//  o_product_hi   out  WIDTH    upper product word
//  o_product_lo   out  WIDTH    lower product word
//  o_alu_a        out  WIDTH    to ALU i_a
//  o_alu_b        out  WIDTH    to ALU i_b
//  o_alu_control  out  3        to ALU i_alucontrol; constant 3'b010
//  i_alu_result   in   WIDTH    from ALU o_result
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE; hi, lo, mcand, count, o_done, o_busy all 0.
//   Reset mid-RUN aborts with no o_done; product regs read 0.
//  Registers: hi[WIDTH], lo[WIDTH], mcand[WIDTH], count[$clog2(WIDTH+1)].
//   o_product_hi=hi and o_product_lo=lo, directly from the registers.
//  ALU drive (combinational from regs): o_alu_a=hi, o_alu_b=mcand, o_alu_control=3'b010,
//   in every state. The ALU has no carry-out, so the block computes the carry itself:
//   c = (hi[MSB]&mcand[MSB]) | ((hi[MSB]|mcand[MSB]) & ~i_alu_result[MSB]).
//  States:
//   IDLE: o_busy=0. On i_start:
//    - i_a==0 or i_b==0: hi=0, lo=0, go to DONE.
//    - otherwise: mcand=i_a, hi=0, lo=i_b, count=WIDTH, go to RUN.
//   RUN: o_busy=1; i_start ignored. Each cycle:
//    - lo[0]=1: {hi,lo} <= {c, i_alu_result, lo[WIDTH-1:1]}.
//    - lo[0]=0: {hi,lo} <= {1'b0, hi, lo[WIDTH-1:1]}; ALU result unused.
//    - count <= count-1; at count==1, go to DONE.
//   DONE: o_done=1 for exactly this cycle; o_busy=0; go to IDLE.
//    i_start here is accepted exactly as in IDLE (back-to-back ops); product regs update at the next edge.
//  Latency, start accepted at edge 0:
//   - normal: o_done high in cycle WIDTH+1.
//   - zero operand: o_done high in cycle 1.
//  Product regs hold their value after DONE until the next accepted start.
//  During RUN they show partial values, not a result.
//  Arithmetic: unsigned only; the full 2*WIDTH product is exact, so there is no overflow.
//  i_a/i_b changes after acceptance have no effect.
// TESTING (WIDTH=32)
//  1. a=7, b=6 -> o_done in cycle 33, o_busy high cycles 1..32; hi=0, lo=42.
//  2. a=b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001 (exercises carry path).
//  3. a=0, b=5 -> o_done in cycle 1, o_busy never high, product 0; same for a=5, b=0.
//  4. a=3, b=4 then i_start held high with a=9, b=9 through RUN -> only 12 produced;
//     second op starts in the DONE cycle, giving 81 exactly 33 cycles later.
//  5. a=5, b=5, i_rst_n low at cycle 10 -> no o_done, o_busy=0 and product=0 immediately
//     (async); after release, a=2, b=3 gives 6.
//  6. Check o_alu_control==3'b010 at all times; random 1000 pairs vs 64-bit reference model.

Source files
------------

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle unsigned shift-add multiplier that borrows the shared
// combinational ALU for every addition. An accepted start latches the
// operands. The block then runs one shift-add step per cycle for WIDTH
// cycles and pulses o_done with the full 2*WIDTH product.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        start request, accepted when o_busy=0 (IDLE or DONE)
//   i_a, i_b       multiplicand / multiplier, sampled on accepted start
//   o_busy         high while the shift-add loop runs
//   o_done         one-cycle pulse, product valid
//   o_product_hi   upper product word (register hi)
//   o_product_lo   lower product word (register lo)
//   o_alu_a        ALU operand a = hi
//   o_alu_b        ALU operand b = multiplicand
//   o_alu_control  ALU operation select, always add (3'b010)
//   i_alu_result   ALU sum, hi + multiplicand
// ---------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product_hi,
    output logic [WIDTH-1:0] o_product_lo,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [2:0]       o_alu_control,
    input  logic [WIDTH-1:0] i_alu_result
);

    localparam int         CW      = $clog2(WIDTH + 1);
    localparam logic [2:0] ALU_ADD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mcand;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic             w_carry;

    // The ALU has no carry-out, so the carry is recovered from the operand
    // MSBs and the sum MSB.
    function automatic logic add_carry(input logic a_msb, input logic b_msb,
                                       input logic s_msb);
        return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
    endfunction

    // ALU drive and carry recovery, combinational from the registers
    always_comb begin
        o_alu_a       = r_hi;
        o_alu_b       = r_mcand;
        o_alu_control = ALU_ADD;
        w_carry       = add_carry(r_hi[WIDTH-1], r_mcand[WIDTH-1],
                                  i_alu_result[WIDTH-1]);
    end

    // Sequencer FSM with registered busy/done flags and product registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
            r_mcand <= {WIDTH{1'b0}};
            r_count <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a new start exactly like IDLE (back-to-back ops)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        if ((i_a == {WIDTH{1'b0}}) || (i_b == {WIDTH{1'b0}})) begin
                            // Zero operand: product is trivially 0, skip the loop
                            r_hi    <= {WIDTH{1'b0}};
                            r_lo    <= {WIDTH{1'b0}};
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_mcand <= i_a;
                            r_hi    <= {WIDTH{1'b0}};
                            r_lo    <= i_b;
                            r_count <= CW'(WIDTH);
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // lo doubles as the multiplier: its LSB selects add-or-skip,
                    // and product bits shift in from the top as it drains.
                    if (r_lo[0]) begin
                        {r_hi, r_lo} <= {w_carry, i_alu_result, r_lo[WIDTH-1:1]};
                    end else begin
                        {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
                    end
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_product_hi = r_hi;
    assign o_product_lo = r_lo;

endmodule

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_seq
// Bench for alu_mul_seq with WIDTH=32. A behavioural add stands in for the
// shared ALU. Every product is compared against a 64-bit multiplication,
// and latency is compared against the expected cycle count.
// ---------------------------------------------------------------------------
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctl;
    logic [31:0] alu_res;

    int total = 0;
    int bad   = 0;

    alu_mul_seq #(.WIDTH(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_a           (a),
        .i_b           (b),
        .o_busy        (busy),
        .o_done        (done),
        .o_product_hi  (p_hi),
        .o_product_lo  (p_lo),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_control (alu_ctl),
        .i_alu_result  (alu_res)
    );

    // Shared ALU stand-in: add operation only
    assign alu_res = alu_a + alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ALU control must read add at all times
    always @(negedge clk) begin
        check("alu_ctl", {61'd0, alu_ctl}, 64'd2);
    end

    // Launch one operation (start seen at edge 0) and measure the cycle in
    // which done rises; also checks busy per cycle, product, and hold.
    task automatic do_op(input string tag, input logic [31:0] opa, input logic [31:0] opb);
        int          lat;
        int          lat_exp;
        logic [63:0] exp_p;
        exp_p   = 64'(opa) * 64'(opb);
        lat_exp = ((opa == 32'd0) || (opb == 32'd0)) ? 1 : 33;
        @(negedge clk);
        start = 1'b1; a = opa; b = opb;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            check({tag, "_busy"}, {63'd0, busy}, {63'd0, (n < lat_exp) ? 1'b1 : 1'b0});
            @(posedge clk); #1;
        end
        check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_prod"}, {p_hi, p_lo}, exp_p);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_hold"}, {p_hi, p_lo}, exp_p);
    endtask

    initial begin
        int          lat;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_prod", {p_hi, p_lo}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed cases
        do_op("t1_7x6", 32'd7, 32'd6);
        do_op("t2_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t2_hi", {32'd0, p_hi}, 64'h0000_0000_FFFF_FFFE);
        check("t2_lo", {32'd0, p_lo}, 64'd1);
        do_op("t3_a0", 32'd0, 32'd5);
        do_op("t3_b0", 32'd5, 32'd0);
        do_op("msb_mcand", 32'h8000_0001, 32'h0000_0003);

        // Start held through RUN: only the first op runs; the second
        // starts in the DONE cycle and completes 33 cycles later.
        @(negedge clk);
        start = 1'b1; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        a = 32'd9; b = 32'd9;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin lat = n; break; end
            @(posedge clk); #1;
        end
        check("t4_lat1", 64'(lat), 64'd33);
        check("t4_prod1", {p_hi, p_lo}, 64'd12);
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_busy2", {63'd0, busy}, 64'd1);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin lat = n; break; end
            @(posedge clk); #1;
        end
        check("t4_lat2", 64'(lat), 64'd33);
        check("t4_prod2", {p_hi, p_lo}, 64'd81);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        start = 1'b1; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", {63'd0, busy}, 64'd0);
        check("t5_done", {63'd0, done}, 64'd0);
        check("t5_prod", {p_hi, p_lo}, 64'd0);
        lat = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) lat++;
        end
        check("t5_nodone", 64'(lat), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        do_op("t5_2x3", 32'd2, 32'd3);

        // Random pairs against the 64-bit reference product
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 8)
                0: ra = ra >> $urandom_range(31, 0);
                1: rb = rb >> $urandom_range(31, 0);
                2: ra = ra | 32'h8000_0000;
                default: ;
            endcase
            do_op("rand", ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
